// File: rtl/triangle_pkg.sv
// Types shared between the triangle generator and the triangle analyzer.
package triangle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        UP,
        DOWN
    } analyzer_state_t;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

endpackage

// File: rtl/triangle_analyzer_if.sv
// Sample-in / verdict-out bundle of the triangle analyzer.
interface triangle_analyzer_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned PW = 16,
    parameter int unsigned EW = 8
);
    logic                ena;
    logic [N-1:0]        in;
    triangle_pkg::dir_t  dir;
    logic                locked;
    logic                peak;
    logic                trough;
    logic                err;
    logic [EW-1:0]       err_count;
    logic [PW-1:0]       period;
    logic                period_valid;

    modport master (
        output ena, in,
        input  dir, locked, peak, trough, err, err_count, period, period_valid
    );

    modport slave (
        input  ena, in,
        output dir, locked, peak, trough, err, err_count, period, period_valid
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over inc. Synchronous active-low reset.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/triangle_analyzer.sv
// Locks onto a +/-1 triangle sample stream, flags peaks/troughs/step errors.
// Period measurement is built only when TRIANGLE_ANALYZER_PERIOD_EN is defined.
module triangle_analyzer
    import triangle_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned PW = 16,
    parameter int unsigned EW = 8
) (
    input logic          clk,
    input logic          rst,
    triangle_analyzer_if.slave bus
);
    localparam logic [N-1:0] Max   = '1;
    localparam logic [N-1:0] MaxM1 = Max - N'(1);

    analyzer_state_t state_q, state_d;
    logic [N-1:0]    prev_q, prev_d;
    logic            peak_q, peak_d;
    logic            trough_q, trough_d;
    logic            err_q, err_d;

    // N+1-bit compares so MAX+1 and 0-1 cannot alias onto a legal sample.
    logic up_step, dn_step, cont_up, cont_dn, turn_dn, turn_up;
    assign up_step = ({1'b0, bus.in} == ({1'b0, prev_q} + (N+1)'(1)));
    assign dn_step = ({1'b0, bus.in} == ({1'b0, prev_q} - (N+1)'(1)));
    assign cont_up = (prev_q != Max) && up_step;
    assign cont_dn = (prev_q != '0) && dn_step;
    assign turn_dn = (prev_q == Max) && (bus.in == MaxM1);
    assign turn_up = (prev_q == '0) && (bus.in == N'(1));

    assign prev_d = bus.ena ? bus.in : prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            peak_q   <= 1'b0;
            trough_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            peak_q   <= peak_d;
            trough_q <= trough_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.ena) begin
            unique case (state_q)
                IDLE: state_d = ACQ;
                ACQ: begin
                    if (up_step)      state_d = UP;
                    else if (dn_step) state_d = DOWN;
                end
                UP: begin
                    if (cont_up)      state_d = UP;
                    else if (turn_dn) state_d = DOWN;
                    else              state_d = ACQ;
                end
                DOWN: begin
                    if (cont_dn)      state_d = DOWN;
                    else if (turn_up) state_d = UP;
                    else              state_d = ACQ;
                end
            endcase
        end
    end

    always_comb begin
        peak_d   = 1'b0;
        trough_d = 1'b0;
        err_d    = 1'b0;
        if (bus.ena) begin
            unique case (state_q)
                IDLE, ACQ: ;
                UP: begin
                    peak_d = turn_dn;
                    err_d  = !cont_up && !turn_dn;
                end
                DOWN: begin
                    trough_d = turn_up;
                    err_d    = !cont_dn && !turn_up;
                end
            endcase
        end
    end

    assign bus.locked = (state_q == UP) || (state_q == DOWN);
    assign bus.dir    = (state_q == DOWN) ? DIR_DOWN : DIR_UP;
    assign bus.peak   = peak_q;
    assign bus.trough = trough_q;
    assign bus.err    = err_q;

    sat_counter #(.W(EW)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_d),
        .clr   (1'b0),
        .count (bus.err_count)
    );

`ifdef TRIANGLE_ANALYZER_PERIOD_EN
    logic [PW-1:0] cnt;
    logic [PW-1:0] period_q;
    logic          period_valid_q;
    logic          seen_q;
    logic          seen_clr;

    // Errors always land in ACQ, so IDLE->ACQ is the only other entry to cover.
    assign seen_clr = err_d || (bus.ena && (state_q == IDLE));

    sat_counter #(.W(PW)) u_period_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.ena),
        .clr   (trough_d),
        .count (cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            seen_q         <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else begin
            if (trough_d)      seen_q <= 1'b1;
            else if (seen_clr) seen_q <= 1'b0;
            period_valid_q <= trough_d && seen_q;
            if (trough_d && seen_q) period_q <= cnt + PW'(1);
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
`else
    assign bus.period       = '0;
    assign bus.period_valid = 1'b0;
`endif
endmodule

// File: tb/tb_triangle_analyzer.sv
// Directed bench for triangle_analyzer: ideal streams, random ena, reset and error table.
module tb_triangle_analyzer;
    import triangle_pkg::*;

    localparam int unsigned N  = 8;
    localparam int unsigned PW = 16;
    localparam int unsigned EW = 8;
`ifdef TRIANGLE_ANALYZER_PERIOD_EN
    localparam bit PerEn = 1'b1;
`else
    localparam bit PerEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    triangle_analyzer_if #(.N(N), .PW(PW), .EW(EW)) bus ();

    triangle_analyzer #(.N(N), .PW(PW), .EW(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit ena;
        int din;
        bit lk;
        bit dr;
        bit pk;
        bit tr;
        bit er;
        int errc;
    } vec_t;

    vec_t vecs[26];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string t, input bit lk, input bit dr, input bit pk,
                             input bit tr, input bit er, input int errc, input int per,
                             input bit pv);
        chk({t, " locked"}, int'(bus.locked), int'(lk));
        if (lk) chk({t, " dir"}, int'(bus.dir), int'(dr));
        chk({t, " peak"}, int'(bus.peak), int'(pk));
        chk({t, " trough"}, int'(bus.trough), int'(tr));
        chk({t, " err"}, int'(bus.err), int'(er));
        chk({t, " err_count"}, int'(bus.err_count), errc);
        chk({t, " period"}, int'(bus.period), per);
        chk({t, " period_valid"}, int'(bus.period_valid), int'(pv));
    endtask

    task automatic drive(input bit e, input int v);
        @(negedge clk);
        bus.ena = e;
        bus.in  = 8'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        bus.ena = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Ideal triangle from 'start'; expectations follow from stream position only.
    task automatic run_stream(input string tag, input int start, input bit go_up,
                              input int n, input bit rand_ena);
        int cur, prev_v, idx, troughs, exp_per, cycles;
        bit up, lk, dr, e, pk, tr, pv;
        cur = start; up = go_up; prev_v = 0; idx = 0; troughs = 0;
        exp_per = 0; cycles = 0; lk = 0; dr = 0;
        while (idx < n && cycles < 8 * n) begin
            e  = rand_ena ? 1'($urandom_range(0, 1)) : 1'b1;
            pk = 0; tr = 0; pv = 0;
            drive(e, cur);
            cycles++;
            if (e) begin
                if (idx >= 1) begin
                    lk = 1;
                    dr = (cur < prev_v);
                end
                pk = (idx >= 2) && (prev_v == 255);
                tr = (idx >= 2) && (prev_v == 0);
                if (tr) troughs++;
                pv = PerEn && tr && (troughs >= 2);
                if (pv) exp_per = 510;
                prev_v = cur;
                idx++;
                if (up) begin
                    if (cur == 255) begin up = 0; cur = 254; end
                    else cur++;
                end else begin
                    if (cur == 0) begin up = 1; cur = 1; end
                    else cur--;
                end
            end
            check_all($sformatf("%s[%0d]", tag, idx), lk, dr, pk, tr, 1'b0, 0, exp_per, pv);
        end
        chk({tag, " samples accepted"}, idx, n);
    endtask

    initial begin
        vecs[0]  = '{1, 98,  0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 99,  1, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 100, 1, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 102, 0, 0, 0, 0, 1, 1};
        vecs[4]  = '{1, 103, 1, 0, 0, 0, 0, 1};
        vecs[5]  = '{1, 104, 1, 0, 0, 0, 0, 1};
        vecs[6]  = '{0, 50,  1, 0, 0, 0, 0, 1};
        vecs[7]  = '{1, 105, 1, 0, 0, 0, 0, 1};
        vecs[8]  = '{1, 105, 0, 0, 0, 0, 1, 2};
        vecs[9]  = '{1, 104, 1, 1, 0, 0, 0, 2};
        vecs[10] = '{1, 103, 1, 1, 0, 0, 0, 2};
        vecs[11] = '{1, 0,   0, 0, 0, 0, 1, 3};
        vecs[12] = '{1, 1,   1, 0, 0, 0, 0, 3};
        vecs[13] = '{1, 0,   0, 0, 0, 0, 1, 4};
        vecs[14] = '{1, 255, 0, 0, 0, 0, 0, 4};
        vecs[15] = '{1, 0,   0, 0, 0, 0, 0, 4};
        vecs[16] = '{1, 1,   1, 0, 0, 0, 0, 4};
        vecs[17] = '{1, 1,   0, 0, 0, 0, 1, 5};
        vecs[18] = '{1, 0,   1, 1, 0, 0, 0, 5};
        vecs[19] = '{1, 1,   1, 0, 0, 1, 0, 5};
        vecs[20] = '{1, 2,   1, 0, 0, 0, 0, 5};
        vecs[21] = '{1, 254, 0, 0, 0, 0, 1, 6};
        vecs[22] = '{1, 255, 1, 0, 0, 0, 0, 6};
        vecs[23] = '{1, 254, 1, 1, 1, 0, 0, 6};
        vecs[24] = '{0, 7,   1, 1, 0, 0, 0, 6};
        vecs[25] = '{1, 253, 1, 1, 0, 0, 0, 6};

        bus.ena = 1'b0;
        bus.in  = '0;
        rst     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("reset dir", int'(bus.dir), 0);
        @(negedge clk);
        rst = 1'b1;

        run_stream("up", 0, 1'b1, 1600, 1'b0);

        do_reset();
        run_stream("rand_ena", 0, 1'b1, 1600, 1'b1);

        do_reset();
        run_stream("down", 200, 1'b0, 788, 1'b0);

        // Reset mid-ramp at 77 with ena still high: reset must win.
        @(negedge clk);
        rst     = 1'b0;
        bus.ena = 1'b1;
        bus.in  = 8'd78;
        @(posedge clk);
        #1;
        check_all("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("midrst dir", int'(bus.dir), 0);
        @(negedge clk);
        rst     = 1'b1;
        bus.in  = 8'd79;
        @(posedge clk);
        #1;
        check_all("midrst first", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 80);
        check_all("midrst relock", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

        do_reset();
        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].ena, vecs[i].din);
            check_all($sformatf("vec%0d", i), vecs[i].lk, vecs[i].dr, vecs[i].pk,
                      vecs[i].tr, vecs[i].er, vecs[i].errc, 0, 1'b0);
        end

        @(negedge clk);
        rst     = 1'b0;
        bus.ena = 1'b1;
        bus.in  = 8'd9;
        @(posedge clk);
        #1;
        chk("final rst err_count", int'(bus.err_count), 0);
        chk("final rst locked", int'(bus.locked), 0);
        @(negedge clk);
        rst     = 1'b1;
        bus.ena = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
